// File: rtl/mux_nto1_scan_if.sv
// Bus bundle for mux_nto1_scan: channel data and select controls in, sample and status out.
// ch_mask exists only when MUX_SKIP_MASK_EN is defined.
interface mux_nto1_scan_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SW = $clog2(N);

    logic [N*WIDTH-1:0] d_in;
    logic [SW-1:0]      sel_in;
    logic               sel_load;
    logic               scan;
`ifdef MUX_SKIP_MASK_EN
    logic [N-1:0]       ch_mask;
`endif
    logic [WIDTH-1:0]   y;
    logic [SW-1:0]      ch;
    logic               y_valid;
    logic               wrap;

`ifdef MUX_SKIP_MASK_EN
    modport master (output d_in, sel_in, sel_load, scan, ch_mask,
                    input  y, ch, y_valid, wrap);
    modport slave  (input  d_in, sel_in, sel_load, scan, ch_mask,
                    output y, ch, y_valid, wrap);
`else
    modport master (output d_in, sel_in, sel_load, scan,
                    input  y, ch, y_valid, wrap);
    modport slave  (input  d_in, sel_in, sel_load, scan,
                    output y, ch, y_valid, wrap);
`endif
endinterface

// File: rtl/mux_nto1_scan.sv
// N:1 registered mux with manual select and auto-scan (programmable dwell per channel).
// Optional MUX_SKIP_MASK_EN: scan skips channels whose ch_mask bit is clear.
module mux_nto1_scan #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_nto1_scan_if.slave   bus
);
    localparam int SW = $clog2(N);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

    state_t           state_p0, state_nx;
    logic [CW-1:0]    cnt_p0, cnt_nx;
    logic [SW-1:0]    ch_p0, ch_nx;
    logic [WIDTH-1:0] y_p0, y_nx;
    logic             vld_p0, vld_nx;
    logic             wrap_p0, wrap_nx;

    logic [SW-1:0]    adv_ch;
    logic             adv_wrap;
    logic             adv_ok;
    logic [WIDTH-1:0] chan [N];

    function automatic logic [SW-1:0] sat_sel(input logic [SW-1:0] s);
        if (int'(s) > N - 1)
            return SW'(N - 1);
        return s;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan[k] = bus.d_in[k*WIDTH +: WIDTH];
    end

    // Channel the scan moves to at the end of a dwell, and whether that move wraps.
    always_comb begin
        adv_ch   = ch_p0;
        adv_wrap = 1'b0;
        adv_ok   = 1'b0;
`ifdef MUX_SKIP_MASK_EN
        for (int k = 1; k <= N; k++) begin
            if (!adv_ok && bus.ch_mask[SW'((int'(ch_p0) + k) % N)]) begin
                adv_ok   = 1'b1;
                adv_ch   = SW'((int'(ch_p0) + k) % N);
                adv_wrap = (int'(ch_p0) + k) >= N;
            end
        end
`else
        adv_ok = 1'b1;
        if (int'(ch_p0) >= N - 1) begin
            adv_ch   = '0;
            adv_wrap = 1'b1;
        end else begin
            adv_ch   = SW'(int'(ch_p0) + 1);
        end
`endif
    end

    always_comb begin
        state_nx = bus.scan ? SCAN : MANUAL;
        ch_nx    = ch_p0;
        cnt_nx   = '0;
        vld_nx   = 1'b1;
        wrap_nx  = 1'b0;
        if (state_nx == MANUAL) begin
            if (bus.sel_load)
                ch_nx = sat_sel(bus.sel_in);
        end else if (bus.sel_load) begin
            // A reload restarts the dwell and never counts as a wrap.
            ch_nx  = sat_sel(bus.sel_in);
            vld_nx = (CNT_LAST == '0) && adv_ok;
        end else if (state_p0 == MANUAL) begin
            vld_nx = (CNT_LAST == '0) && adv_ok;
        end else if (!adv_ok) begin
            vld_nx = 1'b0;
        end else if (cnt_p0 == CNT_LAST) begin
            ch_nx   = adv_ch;
            wrap_nx = adv_wrap;
            vld_nx  = (CNT_LAST == '0);
        end else begin
            cnt_nx = cnt_p0 + CW'(1);
            vld_nx = (cnt_nx == CNT_LAST);
        end
        y_nx = chan[ch_nx];
    end

    // Output register stage: y and ch always updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= MANUAL;
            cnt_p0   <= '0;
            ch_p0    <= '0;
            y_p0     <= '0;
            vld_p0   <= 1'b0;
            wrap_p0  <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            cnt_p0   <= cnt_nx;
            ch_p0    <= ch_nx;
            y_p0     <= y_nx;
            vld_p0   <= vld_nx;
            wrap_p0  <= wrap_nx;
        end
    end

    assign bus.y       = y_p0;
    assign bus.ch      = ch_p0;
    assign bus.y_valid = vld_p0;
    assign bus.wrap    = wrap_p0;
endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
- Parametrised N:1 multiplexer with a registered output.
- Successor to the 2:1 gate-level mux slice: generalised in data width and channel count.
- Adds a select register and an auto-scan mode that steps through channels with a programmable dwell time.
- Sits between multiple sample sources and a single downstream consumer (display/ADC-style sampling path).

Parameters:
- WIDTH, 8, data width of each channel.
- N, 4, number of input channels; legal range N >= 2.
- DWELL, 4, cycles spent on each channel in scan mode; legal range DWELL >= 1.
- SW, $clog2(N), select width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- d_in  in  N*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- sel_in  in  SW  channel index to load.
- sel_load  in  1  load sel_in into the channel register this cycle.
- scan  in  1  0 = manual mode, 1 = auto-scan mode; level, sampled every cycle.
- ch_mask  in  N  scan enable per channel; present only with MUX_SKIP_MASK_EN.
- y  out  WIDTH  registered selected data.
- ch  out  SW  channel index currently presented on y.
- y_valid  out  1  y is a qualified sample.
- wrap  out  1  one-cycle pulse when the scan wraps to channel 0.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - y, ch, y_valid, wrap and the dwell counter all clear to 0; state = MANUAL.
  - Reset asserted mid-operation clears everything immediately, independent of clk.
- States: MANUAL and SCAN.
  - Next state = SCAN if scan=1, else MANUAL, evaluated at every edge.
- Channel and data timing:
  - ch_next is the channel chosen at this edge.
  - At each edge: ch <= ch_next and y <= d_in slice[ch_next].
  - y and ch are therefore always consistent. A new selection appears on y one edge after sel_load.
- sel_in >= N (non-power-of-2 N): ch_next saturates to N-1.
- MANUAL:
  - ch_next = sel_in if sel_load=1, else ch.
  - y_valid = 1 on every cycle after the first post-reset edge.
  - wrap = 0.
  - Dwell counter is held at 0.
- SCAN:
  - Dwell counter runs 0..DWELL-1.
  - When the counter = DWELL-1: counter <= 0 and ch_next = (ch+1) mod N.
  - y_valid = 1 only in the cycle where the counter = DWELL-1, i.e. the last settled sample of each dwell.
  - wrap = 1 for exactly one cycle: the cycle in which ch first shows 0 after an advance from N-1.
- Entering SCAN from MANUAL: dwell counter starts at 0; scanning begins on the current ch.
- Leaving SCAN: ch holds its current value; wrap and the counter clear.
- sel_load in SCAN:
  - Takes priority over advance: ch_next = sel_in and the counter <= 0.
  - No wrap pulse is generated, even if sel_in = 0.
- DWELL=1: advance every cycle; y_valid = 1 every cycle.
- d_in changes while ch is held: y tracks d_in slice[ch] with one cycle latency.

Optional Feature:
- Macro: MUX_SKIP_MASK_EN.
- Defined:
  - The ch_mask port exists.
  - In SCAN, an advance moves to the next higher index with its ch_mask bit set, searching circularly.
  - wrap pulses if the search passes from index N-1 to a lower index.
  - If the current channel is the only enabled channel, it re-dwells on itself; wrap pulses on each re-dwell.
  - If ch_mask = 0: ch holds, the counter holds at 0, y_valid = 0, wrap = 0.
  - A masked channel loaded via sel_load is dwelt on once, then skipped.
  - MANUAL mode ignores ch_mask.
- Undefined: the port is absent and all N channels are scanned in order.

Test Plan:
All cases use WIDTH=8, N=4 and d_in channels {0x11,0x22,0x33,0x44} unless stated.
1. Reset: hold rst_n=0, then release with scan=0 -> y=0x00, ch=0, y_valid=0; after the first edge y=0x11, y_valid=1.
2. Manual select: sel_in=2 with sel_load=1 for one cycle -> next edge ch=2, y=0x33; a later change of d_in ch2 to 0x5A -> y=0x5A one cycle after the change.
3. Scan with DWELL=4, starting at ch=0 -> y_valid pulses every 4 cycles with y=0x11, 0x22, 0x33, 0x44, 0x11; wrap pulses exactly once, on the first cycle ch shows 0 after ch=3.
4. sel_in=1, sel_load=1 at dwell count 2 on ch=3 -> ch=1, counter restarts, no wrap pulse, next y_valid 4 cycles later with y=0x22.
5. Scan with DWELL=1 -> ch sequence 0,1,2,3,0 on consecutive cycles, y_valid constantly 1; assert rst_n=0 mid-scan -> outputs clear asynchronously.
6. MUX_SKIP_MASK_EN with ch_mask=4'b1010, DWELL=2 -> ch visits 1,3,1,3 with wrap on each 3->1 transition; ch_mask=0 -> ch holds, y_valid=0.
